// File: rtl/spi_slave_chip.sv
// SPI mode-0 slave puzzle chip: streams a loaded byte image to the master,
// captures a multi-byte answer into result, and flags completion on DONE.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | slave not selected; waits for synchronized ss low
// ST_CMD    | first byte of frame; shifts out status {7'b0, eof}, decodes cmd
// ST_READ   | streams mem[rd_ptr] (0x00 past data_len), rd_ptr advances
// ST_RESULT | each completed received byte shifts into result
// ST_IGNORE | shifts out 0x00 until ss rises
module spi_slave_chip #(
   parameter int DATA_DEPTH   = 4096,
   parameter int ADDR_WIDTH   = 12,
   parameter int RESULT_WIDTH = 32,
   parameter int SYNC_FLOPS   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    spi_sclk,
   input  logic                    spi_mosi,
   input  logic                    spi_ss_out,
   output logic                    spi_miso,
   input  logic                    load_en,
   input  logic [ADDR_WIDTH-1:0]   load_addr,
   input  logic [7:0]              load_data,
   input  logic [ADDR_WIDTH:0]     data_len,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    test_complete
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_READ,
      ST_RESULT,
      ST_IGNORE
   } state_t;

   localparam logic [7:0] CMD_READ   = 8'hA1;
   localparam logic [7:0] CMD_RESULT = 8'hB2;
   localparam logic [7:0] CMD_DONE   = 8'hC3;

   state_t                  state, state_nxt;
   logic [SYNC_FLOPS-1:0]   sclk_sync, mosi_sync, ss_sync;
   logic                    sclk_s, mosi_s, ss_s, sclk_prev;
   logic                    sclk_rise, sclk_fall, byte_done, eof;
   logic [2:0]              bit_cnt;
   logic [6:0]              rx_sr;
   logic [7:0]              rx_byte;
   logic [7:0]              tx_sr;
   logic [ADDR_WIDTH:0]     rd_ptr;
   logic [7:0]              mem [DATA_DEPTH];
   logic [7:0]              mem_rdata;

   // ss synchronizer resets high so MISO is released the instant reset asserts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_sync   <= '1;
         sclk_prev <= 1'b0;
      end else begin
         sclk_sync <= (sclk_sync << 1) | SYNC_FLOPS'(spi_sclk);
         mosi_sync <= (mosi_sync << 1) | SYNC_FLOPS'(spi_mosi);
         ss_sync   <= (ss_sync << 1) | SYNC_FLOPS'(spi_ss_out);
         sclk_prev <= sclk_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_FLOPS-1];
   assign mosi_s    = mosi_sync[SYNC_FLOPS-1];
   assign ss_s      = ss_sync[SYNC_FLOPS-1];
   assign sclk_rise = sclk_s & ~sclk_prev & ~ss_s;
   assign sclk_fall = ~sclk_s & sclk_prev & ~ss_s;
   assign byte_done = sclk_rise && (bit_cnt == 3'd7);
   assign rx_byte   = {rx_sr, mosi_s};
   assign eof       = !(rd_ptr < data_len);

   assign spi_miso  = ss_s ? 1'bz : tx_sr[7];

   always_ff @(posedge clk) begin
      if (load_en && ss_s && (32'(load_addr) < DATA_DEPTH))
         mem[load_addr] <= load_data;
      mem_rdata <= mem[rd_ptr[ADDR_WIDTH-1:0]];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ss_s) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_CMD;
            ST_CMD: begin
               if (byte_done) begin
                  case (rx_byte)
                     CMD_READ:   state_nxt = ST_READ;
                     CMD_RESULT: state_nxt = ST_RESULT;
                     default:    state_nxt = ST_IGNORE;
                  endcase
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt       <= 3'd0;
         rx_sr         <= 7'd0;
         tx_sr         <= 8'd0;
         rd_ptr        <= '0;
         result        <= '0;
         test_complete <= 1'b0;
      end else if (ss_s) begin
         bit_cnt <= 3'd0;
      end else if (state == ST_IDLE) begin
         tx_sr   <= {7'b0, eof};
         bit_cnt <= 3'd0;
      end else begin
         if (sclk_rise) begin
            rx_sr   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (byte_done) begin
            case (state)
               ST_CMD: begin
                  if (rx_byte == CMD_DONE)
                     test_complete <= 1'b1;
               end
               ST_READ: begin
                  if (!eof)
                     rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
               end
               ST_RESULT: result <= {result[RESULT_WIDTH-9:0], rx_byte};
               default: ;
            endcase
         end
         // A fall with bit_cnt wrapped to 0 is the start of the next byte
         if (sclk_fall) begin
            if (bit_cnt == 3'd0)
               tx_sr <= (state == ST_READ && !eof) ? mem_rdata : 8'h00;
            else
               tx_sr <= {tx_sr[6:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_chip.sv
// Bench for spi_slave_chip: two instances share MISO; a scoreboard checks every
// received MISO byte and the result/test_complete state after each frame.
module tb_spi_slave_chip;

   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sclk = 1'b0;
   logic          mosi = 1'b0;
   logic          ss_a = 1'b1;
   logic          ss_b = 1'b1;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [7:0]    load_data = 8'h00;
   logic [AW:0]   data_len = 13'd3;
   logic [31:0]   result_a, result_b;
   logic          tc_a, tc_b;
   wire           miso_bus;

   pullup (miso_bus);

   spi_slave_chip u_dut_a (
      .clk(clk), .reset(rst_n), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_ss_out(ss_a), .spi_miso(miso_bus), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .data_len(data_len),
      .result(result_a), .test_complete(tc_a));

   spi_slave_chip u_dut_b (
      .clk(clk), .reset(rst_n), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_ss_out(ss_b), .spi_miso(miso_bus), .load_en(load_en),
      .load_addr(load_addr), .load_data(load_data), .data_len(data_len),
      .result(result_b), .test_complete(tc_b));

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q [$];
   logic [32:0] res_q [$];
   logic [7:0]  f_tx  [8];
   logic [7:0]  f_exp [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // MISO byte monitor: master-side capture on each sclk rise while selected
   int         mon_bits = 0;
   logic [7:0] mon_cap = 8'h00;
   always @(posedge sclk or posedge ss_a) begin
      if (ss_a) begin
         mon_bits = 0;
      end else begin
         mon_cap = {mon_cap[6:0], miso_bus};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            if (exp_q.size() == 0)
               check("miso_unexpected_byte", {24'h0, mon_cap}, 32'hFFFF_FFFF);
            else
               check("miso_byte", {24'h0, mon_cap}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // Frame-end monitor: result and test_complete settle after ss rises
   always @(posedge ss_a) begin
      logic [32:0] e;
      repeat (8) @(negedge clk);
      if (res_q.size() == 0) begin
         check("frame_unexpected", 32'h0, 32'hFFFF_FFFF);
      end else begin
         e = res_q.pop_front();
         check("frame_result", result_a, e[31:0]);
         check("frame_test_complete", {31'h0, tc_a}, {31'h0, e[32]});
      end
   end

   task automatic sclk_bit(input logic b);
      @(negedge clk) mosi = b;
      repeat (6) @(negedge clk);
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int nbits);
      for (int i = 0; i < nbits; i++)
         sclk_bit(b[7-i]);
   endtask

   task automatic frame(input int n, input int tail, input logic [31:0] er, input logic etc);
      for (int i = 0; i < n; i++)
         exp_q.push_back(f_exp[i]);
      res_q.push_back({etc, er});
      @(negedge clk) ss_a = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < n; i++)
         send_byte(f_tx[i], 8);
      if (tail > 0)
         send_byte(f_tx[n], tail);
      repeat (6) @(negedge clk);
      ss_a = 1'b1;
      repeat (16) @(negedge clk);
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk) rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_result", result_a, 32'h0);
      check("reset_test_complete", {31'h0, tc_a}, 32'h0);
      check("reset_miso_released", {31'h0, miso_bus}, 32'h1);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      load(12'd0, 8'h11);
      load(12'd1, 8'h22);
      load(12'd2, 8'h33);
      load(12'd3, 8'h44);

      // Pointer persists across frames
      f_tx = '{0:8'hA1, default:8'h00}; f_exp = '{0:8'h00, 1:8'h11, default:8'h00};
      frame(2, 0, 32'h0, 1'b0);
      f_tx = '{0:8'hA1, default:8'h00}; f_exp = '{0:8'h00, 1:8'h22, default:8'h00};
      frame(2, 0, 32'h0, 1'b0);

      // Full stream to end of data, then eof status on the next frame
      pulse_reset();
      f_tx = '{0:8'hA1, default:8'h00};
      f_exp = '{0:8'h00, 1:8'h11, 2:8'h22, 3:8'h33, 4:8'h00, default:8'h00};
      frame(5, 0, 32'h0, 1'b0);
      f_tx = '{0:8'hA1, default:8'h00}; f_exp = '{0:8'h01, default:8'h00};
      frame(1, 0, 32'h0, 1'b0);

      // Aborted read byte does not advance the pointer
      pulse_reset();
      f_tx = '{0:8'hA1, 1:8'hFF, default:8'h00}; f_exp = '{0:8'h00, default:8'h00};
      frame(1, 3, 32'h0, 1'b0);
      f_tx = '{0:8'hA1, default:8'h00}; f_exp = '{0:8'h00, 1:8'h11, default:8'h00};
      frame(2, 0, 32'h0, 1'b0);

      // Image write while selected is dropped
      res_q.push_back({1'b0, 32'h0});
      @(negedge clk) ss_a = 1'b0;
      repeat (6) @(negedge clk);
      load(12'd1, 8'hEE);
      repeat (2) @(negedge clk);
      ss_a = 1'b1;
      repeat (16) @(negedge clk);

      // Unknown command: zeros out, nothing changes
      f_tx = '{0:8'h55, 1:8'hA1, 2:8'hB2, default:8'h00};
      f_exp = '{default:8'h00};
      frame(3, 0, 32'h0, 1'b0);
      f_tx = '{0:8'hA1, default:8'h00}; f_exp = '{0:8'h00, 1:8'h22, default:8'h00};
      frame(2, 0, 32'h0, 1'b0);

      // Answer capture, then DONE (twice) leaves result intact
      f_tx = '{0:8'hB2, 1:8'h00, 2:8'h00, 3:8'h42, 4:8'h6F, default:8'h00};
      f_exp = '{default:8'h00};
      frame(5, 0, 32'h0000_426F, 1'b0);
      f_tx = '{0:8'hC3, 1:8'hC3, default:8'h00}; f_exp = '{default:8'h00};
      frame(2, 0, 32'h0000_426F, 1'b1);

      // Partial answer byte is discarded
      pulse_reset();
      f_tx = '{0:8'hB2, 1:8'h12, 2:8'hFF, default:8'h00}; f_exp = '{default:8'h00};
      frame(2, 3, 32'h0000_0012, 1'b0);

      // Reset mid-RESULT frame with ss still low
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      res_q.push_back({1'b0, 32'h0});
      @(negedge clk) ss_a = 1'b0;
      repeat (6) @(negedge clk);
      send_byte(8'hB2, 8);
      send_byte(8'h34, 8);
      send_byte(8'h56, 8);
      send_byte(8'h78, 4);
      repeat (2) @(negedge clk);
      check("mid_frame_result", result_a, 32'h0012_3456);
      rst_n = 1'b0;
      #1;
      check("async_reset_result", result_a, 32'h0);
      check("async_reset_test_complete", {31'h0, tc_a}, 32'h0);
      check("async_reset_miso_released", {31'h0, miso_bus}, 32'h1);
      @(negedge clk) ss_a = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (16) @(negedge clk);

      f_tx = '{0:8'hC3, default:8'h00}; f_exp = '{default:8'h00};
      frame(1, 0, 32'h0, 1'b1);

      check("idle_miso_released", {31'h0, miso_bus}, 32'h1);
      check("unselected_result", result_b, 32'h0);
      check("unselected_test_complete", {31'h0, tc_b}, 32'h0);
      check("miso_bytes_outstanding", exp_q.size(), 32'h0);
      check("frames_outstanding", res_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
